// File: rtl/axi4lite2sram.sv
// rtl/axi4lite2sram.sv - AXI4-Lite slave to single-port SRAM bridge (optional macro AXI4LITE2SRAM_ADDR_CHECK_EN)
module axi4lite2sram #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MEM_WORDS = 1024,
    parameter int MAW       = $clog2(MEM_WORDS)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                axi_awvalid,
    input  logic [AW-1:0]       axi_awaddr,
    input  logic [2:0]          axi_awport,
    output logic                axi_awready,
    input  logic                axi_wvalid,
    input  logic [DW-1:0]       axi_wdata,
    input  logic [DW/8-1:0]     axi_wstrb,
    output logic                axi_wready,
    output logic                axi_bvalid,
    output logic [1:0]          axi_bresp,
    input  logic                axi_bready,
    input  logic                axi_arvalid,
    input  logic [AW-1:0]       axi_araddr,
    input  logic [2:0]          axi_arport,
    output logic                axi_arready,
    output logic                axi_rvalid,
    output logic [DW-1:0]       axi_rdata,
    output logic [1:0]          axi_rresp,
    input  logic                axi_rready,
    output logic                mem_en,
    output logic [DW/8-1:0]     mem_we,
    output logic [MAW-1:0]      mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int OFF = $clog2(DW/8);

    typedef enum logic [1:0] {IDLE, WR_RESP, RD_DATA, RD_RESP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     resp_q, resp_d;
    logic [DW-1:0]  rdata_q;
    logic           aw_err, ar_err;
    logic [MAW-1:0] aw_idx, ar_idx;
    logic           both_valid;
    logic           unused_ok;

    assign aw_idx     = axi_awaddr[MAW+OFF-1:OFF];
    assign ar_idx     = axi_araddr[MAW+OFF-1:OFF];
    assign both_valid = axi_awvalid & axi_wvalid;

`ifdef AXI4LITE2SRAM_ADDR_CHECK_EN
    localparam logic [MAW:0] MEM_WORDS_W = MEM_WORDS[MAW:0];

    // Out of range when the word index exceeds the array or any upper address bit is set
    function automatic logic addr_bad(input logic [AW-1:0] a);
        logic [MAW:0] idx;
        idx = {1'b0, a[MAW+OFF-1:OFF]};
        return (idx >= MEM_WORDS_W) || ((a >> (MAW + OFF)) != '0);
    endfunction

    assign aw_err = addr_bad(axi_awaddr);
    assign ar_err = addr_bad(axi_araddr);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Port ids and the address bits outside the word index carry no meaning here
    assign unused_ok = ^{axi_awport, axi_arport, axi_awaddr, axi_araddr};

    assign mem_wdata  = axi_wdata;
    assign axi_bvalid = (state_q == WR_RESP);
    assign axi_rvalid = (state_q == RD_RESP);
    assign axi_bresp  = resp_q;
    assign axi_rresp  = resp_q;
    assign axi_rdata  = rdata_q;

    // Next state, handshake readies and the single-cycle SRAM access strobe
    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_arready = 1'b0;
        mem_en      = 1'b0;
        mem_we      = '0;
        mem_addr    = '0;
        unique case (state_q)
            IDLE: begin
                axi_awready = both_valid;
                axi_wready  = both_valid;
                axi_arready = ~both_valid;
                if (both_valid) begin
                    state_d  = WR_RESP;
                    resp_d   = aw_err ? 2'b10 : 2'b00;
                    mem_en   = ~aw_err;
                    mem_we   = aw_err ? '0 : axi_wstrb;
                    mem_addr = aw_idx;
                end else if (axi_arvalid) begin
                    state_d  = RD_DATA;
                    resp_d   = ar_err ? 2'b10 : 2'b00;
                    mem_en   = ~ar_err;
                    mem_addr = ar_idx;
                end
            end
            WR_RESP: if (axi_bready) state_d = IDLE;
            RD_DATA: state_d = RD_RESP;
            RD_RESP: if (axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Reset blocks every handshake and SRAM access immediately
        if (rst_b) begin
            axi_awready = 1'b0;
            axi_wready  = 1'b0;
            axi_arready = 1'b0;
            mem_en      = 1'b0;
            mem_we      = '0;
        end
    end

    // State, stored response and read holding register
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= IDLE;
            resp_q  <= 2'b00;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            if (state_q == RD_DATA) begin
                rdata_q <= (resp_q == 2'b00) ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite2sram.sv
// tb/tb_axi4lite2sram.sv - self-checking bench for axi4lite2sram
module tb_axi4lite2sram;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [31:0] axi_awaddr, axi_wdata;
    logic [2:0]  axi_awport, axi_arport;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [31:0] axi_araddr, axi_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] sram    [1024];
    logic [31:0] ref_mem [1024];

    axi4lite2sram #(.DW(32), .AW(32), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst_b(rst_b),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awport(axi_awport),
        .axi_awready(axi_awready), .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
        .axi_bresp(axi_bresp), .axi_bready(axi_bready),
        .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arport(axi_arport),
        .axi_arready(axi_arready), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rready(axi_rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM with one-cycle read latency and byte write enables
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef AXI4LITE2SRAM_ADDR_CHECK_EN
        return a >= 32'h0000_1000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_resp, input int dly);
        int n;
        logic bd;
        bd = addr_bad(a);
        @(posedge clk); #1;
        axi_awvalid = 1; axi_awaddr = a; axi_wvalid = 1; axi_wdata = d; axi_wstrb = s; axi_bready = 0;
        n = 0;
        @(negedge clk);
        while (!axi_awready && n < 20) begin @(negedge clk); n++; end
        chk("wr_handshake", 32'(n < 20), 32'd1);
        if (n >= 20) begin axi_awvalid = 0; axi_wvalid = 0; return; end
        chk("wr_wready", 32'(axi_wready), 32'd1);
        chk("wr_mem_en", 32'(mem_en), 32'(!bd));
        chk("wr_mem_we", 32'(mem_we), bd ? 32'd0 : 32'(s));
        if (!bd) begin
            chk("wr_mem_addr", 32'(mem_addr), 32'(word_of(a)));
            chk("wr_mem_wdata", mem_wdata, d);
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[word_of(a)][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk); #1;
        axi_awvalid = 0; axi_wvalid = 0;
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("wr_bvalid_hold", 32'(axi_bvalid), 32'd1);
            chk("wr_ready_busy", 32'(axi_arready), 32'd0);
            @(posedge clk); #1;
        end
        axi_bready = 1;
        @(negedge clk);
        chk("wr_bvalid", 32'(axi_bvalid), 32'd1);
        chk("wr_bresp", 32'(axi_bresp), 32'(exp_resp));
        chk("wr_mem_idle", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        axi_bready = 0;
        @(negedge clk);
        chk("wr_bvalid_drop", 32'(axi_bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int dly);
        int n;
        logic bd;
        bd = addr_bad(a);
        @(posedge clk); #1;
        axi_arvalid = 1; axi_araddr = a; axi_rready = 0;
        n = 0;
        @(negedge clk);
        while (!axi_arready && n < 20) begin @(negedge clk); n++; end
        chk("rd_handshake", 32'(n < 20), 32'd1);
        if (n >= 20) begin axi_arvalid = 0; return; end
        chk("rd_mem_en", 32'(mem_en), 32'(!bd));
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        if (!bd) chk("rd_mem_addr", 32'(mem_addr), 32'(word_of(a)));
        @(posedge clk); #1;
        axi_arvalid = 0;
        @(negedge clk);
        chk("rd_rvalid_early", 32'(axi_rvalid), 32'd0);
        chk("rd_mem_quiet", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("rd_rvalid_hold", 32'(axi_rvalid), 32'd1);
            chk("rd_rdata_hold", axi_rdata, exp_data);
            @(posedge clk); #1;
        end
        axi_rready = 1;
        @(negedge clk);
        chk("rd_rvalid", 32'(axi_rvalid), 32'd1);
        chk("rd_rdata", axi_rdata, exp_data);
        chk("rd_rresp", 32'(axi_rresp), 32'(exp_resp));
        @(posedge clk); #1;
        axi_rready = 0;
        @(negedge clk);
        chk("rd_rvalid_drop", 32'(axi_rvalid), 32'd0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, e;
        logic [3:0]  s;
        logic [1:0]  r;
        int          w;

        for (int i = 0; i < 1024; i++) begin sram[i] = '0; ref_mem[i] = '0; end
        mem_rdata = '0;
        rst_b = 1; axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; axi_bready = 0; axi_rready = 0;
        axi_awaddr = 0; axi_araddr = 0; axi_wdata = 0; axi_wstrb = 0; axi_awport = 0; axi_arport = 0;

        tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00};
        tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        tbl[2] = '{1'b1, 32'h0000_0010, 32'h0000_AB00, 4'h2, 32'h0, 2'b00};
        tbl[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 2'b00};
        tbl[4] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 32'h0, 2'b00};
        tbl[5] = '{1'b0, 32'h0000_0FFF, 32'h0,         4'h0, 32'h1234_5678, 2'b00};
        tbl[6] = '{1'b1, 32'h0000_0022, 32'hA5A5_A5A5, 4'h9, 32'h0, 2'b00};
        tbl[7] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hA500_00A5, 2'b00};

        // reset values and readies blocked while reset is held
        @(posedge clk); @(posedge clk); #1;
        axi_awvalid = 1; axi_wvalid = 1; axi_arvalid = 1;
        @(negedge clk);
        chk("rst_bvalid", 32'(axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
        chk("rst_rdata", axi_rdata, 32'd0);
        chk("rst_bresp", 32'(axi_bresp), 32'd0);
        chk("rst_rresp", 32'(axi_rresp), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_awready", 32'(axi_awready), 32'd0);
        chk("rst_arready", 32'(axi_arready), 32'd0);
        @(posedge clk); #1;
        axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; rst_b = 0;

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_resp, i % 3);
            else              axi_read(tbl[i].addr, tbl[i].exp_rd, tbl[i].exp_resp, i % 3);
        end

        // simultaneous write and read: write wins, read waits for the B handshake
        @(posedge clk); #1;
        axi_awvalid = 1; axi_awaddr = 32'h40; axi_wvalid = 1; axi_wdata = 32'hCAFE_F00D; axi_wstrb = 4'hF;
        axi_arvalid = 1; axi_araddr = 32'h40; axi_bready = 0; axi_rready = 0;
        @(negedge clk);
        chk("prio_awready", 32'(axi_awready), 32'd1);
        chk("prio_arready", 32'(axi_arready), 32'd0);
        @(posedge clk); #1;
        axi_awvalid = 0; axi_wvalid = 0;
        ref_mem[16] = 32'hCAFE_F00D;
        @(negedge clk);
        chk("prio_bvalid", 32'(axi_bvalid), 32'd1);
        chk("prio_ar_wait", 32'(axi_arready), 32'd0);
        @(posedge clk); #1;
        axi_bready = 1;
        @(negedge clk);
        chk("prio_ar_wait2", 32'(axi_arready), 32'd0);
        @(posedge clk); #1;
        axi_bready = 0;
        @(negedge clk);
        chk("prio_arready_after", 32'(axi_arready), 32'd1);
        chk("prio_rd_mem_en", 32'(mem_en), 32'd1);
        @(posedge clk); #1;
        axi_arvalid = 0;
        @(posedge clk); #1;
        axi_rready = 1;
        @(negedge clk);
        chk("prio_rvalid", 32'(axi_rvalid), 32'd1);
        chk("prio_rdata", axi_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        axi_rready = 0;

        // stalled read response, then reset abandons it
        @(posedge clk); #1;
        axi_arvalid = 1; axi_araddr = 32'h10;
        @(negedge clk);
        chk("stall_arready", 32'(axi_arready), 32'd1);
        @(posedge clk); #1;
        axi_arvalid = 0;
        @(posedge clk); #1;
        axi_awvalid = 1; axi_wvalid = 1; axi_awaddr = 32'h80; axi_arvalid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rvalid", 32'(axi_rvalid), 32'd1);
            chk("stall_rdata", axi_rdata, 32'hDEAD_ABEF);
            chk("stall_awready", 32'(axi_awready), 32'd0);
            chk("stall_arready0", 32'(axi_arready), 32'd0);
            chk("stall_mem_en", 32'(mem_en), 32'd0);
            @(posedge clk); #1;
        end
        rst_b = 1;
        @(negedge clk);
        chk("rstmid_awready", 32'(axi_awready), 32'd0);
        chk("rstmid_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_rvalid", 32'(axi_rvalid), 32'd0);
        chk("rstmid_rdata", axi_rdata, 32'd0);
        chk("rstmid_arready", 32'(axi_arready), 32'd0);
        @(posedge clk); #1;
        rst_b = 0; axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;

        // out-of-range address: aliases to word 0 unless checking is enabled
        axi_write(32'h0, 32'h1122_3344, 4'hF, 2'b00, 0);
`ifdef AXI4LITE2SRAM_ADDR_CHECK_EN
        axi_read(32'h0000_1000, 32'h0, 2'b10, 1);
        axi_write(32'h0000_1004, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        axi_read(32'h0000_0004, 32'h0, 2'b00, 0);
`else
        axi_read(32'h0000_1000, 32'h1122_3344, 2'b00, 1);
`endif

        // randomized traffic against the word-array reference
        for (int i = 0; i < 60; i++) begin
            w = $urandom_range(0, 15);
            a = (($urandom_range(0, 7) == 0) ? 32'h0001_0000 : 32'h0) | (32'(w) << 2) | 32'($urandom_range(0, 3));
            r = addr_bad(a) ? 2'b10 : 2'b00;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, r, $urandom_range(0, 2));
            end else begin
                e = addr_bad(a) ? 32'h0 : ref_mem[word_of(a)];
                axi_read(a, e, r, $urandom_range(0, 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4lite2sram.md
AXI4LITE2SRAM -- requirements
Module: axi4lite2sram

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, default 32, AXI byte-address width.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, SRAM depth in DW-bit words; MAW = $clog2(MEM_WORDS).
REQ-004 SHALL have ports: clk in 1 clock; rst_b in 1 reset (one clock; synchronous, active-high: asserted when 1).
REQ-005 SHALL have AXI4-Lite slave ports: axi_awvalid in 1; axi_awaddr in AW; axi_awport in 3 (ignored); axi_awready out 1; axi_wvalid in 1; axi_wdata in DW; axi_wstrb in DW/8; axi_wready out 1; axi_bvalid out 1; axi_bresp out 2; axi_bready in 1.
REQ-006 SHALL have AXI4-Lite read ports: axi_arvalid in 1; axi_araddr in AW; axi_arport in 3 (ignored); axi_arready out 1; axi_rvalid out 1; axi_rdata out DW; axi_rresp out 2; axi_rready in 1.
REQ-007 SHALL have SRAM master ports: mem_en out 1; mem_we out DW/8 (byte write enables); mem_addr out MAW (word index); mem_wdata out DW; mem_rdata in DW (valid exactly 1 cycle after a read with mem_en=1).

Function
REQ-008 SHALL implement FSM states IDLE, WR_RESP, RD_DATA, RD_RESP; one outstanding transaction at most.
REQ-009 In IDLE, axi_awready = axi_wready = axi_awvalid & axi_wvalid (both accepted in same cycle; neither accepted alone).
REQ-010 In IDLE, axi_arready = ~(axi_awvalid & axi_wvalid); simultaneous valid read and write: write wins, read waits.
REQ-011 All *ready outputs SHALL be 0 outside IDLE.
REQ-012 Write handshake cycle: mem_en=1, mem_we=axi_wstrb, mem_addr=axi_awaddr[MAW+log2(DW/8)-1:log2(DW/8)], mem_wdata=axi_wdata (combinational); next state WR_RESP.
REQ-013 WR_RESP: axi_bvalid=1, axi_bresp held stable; on axi_bready=1 return to IDLE next cycle; bvalid stays high indefinitely while bready=0.
REQ-014 Read handshake cycle: mem_en=1, mem_we=0, mem_addr from axi_araddr same slicing; next state RD_DATA.
REQ-015 RD_DATA: register mem_rdata into the read-data holding register; next state RD_RESP unconditionally.
REQ-016 RD_RESP: axi_rvalid=1, axi_rdata/axi_rresp stable from holding register; on axi_rready=1 return to IDLE.
REQ-017 mem_en SHALL be 1 only in handshake cycles; mem_we SHALL be 0 whenever mem_en=0.
REQ-018 Latency: write handshake -> bvalid next cycle; read handshake -> rvalid 2 cycles later; peak throughput 1 write per 2 cycles, 1 read per 3 cycles.
REQ-019 Low address bits below log2(DW/8) SHALL be ignored; axi_bresp/axi_rresp SHALL be 2'b00 (OKAY) unless REQ-023 applies.

Reset
REQ-020 While rst_b=1 at a clk edge: state <= IDLE, read holding register <= 0, stored resp <= 2'b00.
REQ-021 Reset values: axi_bvalid=0, axi_rvalid=0, axi_rdata=0, axi_bresp=axi_rresp=2'b00, mem_en=0, mem_we=0.
REQ-022 Reset mid-transaction SHALL abandon it: pending bvalid/rvalid dropped next cycle, no further SRAM access; readies held 0 during reset.

Configuration
REQ-023 Macro AXI4LITE2SRAM_ADDR_CHECK_EN defined: address with word index >= MEM_WORDS or any nonzero bit above MAW+log2(DW/8)-1 SHALL get resp 2'b10 (SLVERR), mem_en=0 for that handshake, axi_rdata=0; FSM timing unchanged.
REQ-024 Macro undefined: no check, upper address bits discarded, always OKAY.

Verification
REQ-025 Write 0x0000_0010 data 0xDEADBEEF wstrb 4'hF, bready=1 -> mem_we=4'hF, mem_addr=4 in handshake cycle; bvalid next cycle, bresp=00.
REQ-026 Read 0x10 after REQ-025 with SRAM model -> rvalid 2 cycles after arready, rdata=0xDEADBEEF, rresp=00.
REQ-027 wstrb 4'b0010, wdata 0x0000_AB00 to 0x10 then read -> 0xDEADABEF.
REQ-028 awvalid+wvalid+arvalid asserted same cycle -> write accepted first; arready=1 only after bready handshake returns FSM to IDLE.
REQ-029 rready=0 for 5 cycles in RD_RESP -> rvalid/rdata stable, readies 0; rst_b=1 then -> rvalid=0 next cycle.
REQ-030 With AXI4LITE2SRAM_ADDR_CHECK_EN, MEM_WORDS=1024: read 0x0000_1000 -> mem_en=0, rresp=2'b10, rdata=0; without macro -> mem_addr=0, rresp=00.
